mem_bus_responder: RTL and testbench

- Memory-side responder for the internal CPU bus: the far end of the read_q/write_q ↔ read_dn/write_dn handshake that the CPU-side bus initiator drives.
- Decodes the bus address window, services single-word reads and writes against an internal synchronous RAM with programmable wait states, and returns completion strobes and read data.
- Drives the shared OR-combined bus, so every output is zero when not actively responding.

---
 rtl/mem_bus_responder.sv | 137 +++++++++++++
 tb/tb_mem_bus_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the internal CPU bus: decodes a word-address window and
// services single-word reads/writes against a synchronous RAM with programmable wait states.
module mem_bus_responder #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0] BASE       = '0,
    parameter int unsigned       WAIT_RD    = 1,
    parameter int unsigned       WAIT_WR    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_oe,
    input  logic              read_q,
    input  logic              write_q,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              read_dn,
    output logic              write_dn,
    output logic [DATA_W-1:0] data_out,
    output logic              bus_busy,
    output logic              req_err
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_RD_DONE = 3'd2;
    localparam logic [2:0] S_WR_WAIT = 3'd3;
    localparam logic [2:0] S_WR_DONE = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    if (WAIT_RD > 15 || WAIT_WR > 15) begin : g_bad_wait
        $error("mem_bus_responder: WAIT_RD/WAIT_WR must be 0..15");
    end
    if (BASE[DEPTH_LOG2-1:0] != '0) begin : g_bad_base
        $error("mem_bus_responder: BASE must be aligned to the RAM depth");
    end

    logic [2:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q, rdata_q, data_out_q;
    logic                  rd_dn_q, rd_dn_d, wr_dn_q, wr_dn_d, err_q, err_d;
    logic                  latch, ram_we, ram_re, hit;
    logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];

    assign hit = (addr_in[ADDR_W-1:DEPTH_LOG2] == BASE[ADDR_W-1:DEPTH_LOG2]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        rd_dn_d = 1'b0;
        wr_dn_d = 1'b0;
        err_d   = 1'b0;
        if (clk_oe) begin
            case (state_q)
                S_IDLE: begin
                    // Write wins a read/write collision; the collision is flagged.
                    if (write_q && hit) begin
                        state_d = S_WR_WAIT;
                        cnt_d   = 4'(WAIT_WR);
                        latch   = 1'b1;
                        err_d   = read_q;
                    end else if (read_q && hit) begin
                        state_d = S_RD_WAIT;
                        cnt_d   = 4'(WAIT_RD);
                        latch   = 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (!read_q) state_d = S_IDLE;
                    else if (cnt_q == '0) begin
                        ram_re  = 1'b1;
                        state_d = S_RD_DONE;
                    end else cnt_d = cnt_q - 4'd1;
                end
                S_RD_DONE: begin
                    rd_dn_d = 1'b1;
                    state_d = S_RELEASE;
                end
                S_WR_WAIT: begin
                    if (!write_q) state_d = S_IDLE;
                    else if (cnt_q == '0) state_d = S_WR_DONE;
                    else cnt_d = cnt_q - 4'd1;
                end
                S_WR_DONE: begin
                    ram_we  = 1'b1;
                    wr_dn_d = 1'b1;
                    state_d = S_RELEASE;
                end
                S_RELEASE: begin
                    // Wait for the initiator to drop its request so it is not served twice.
                    if (!read_q && !write_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rd_dn_q    <= 1'b0;
            wr_dn_q    <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_dn_q    <= rd_dn_d;
            wr_dn_q    <= wr_dn_d;
            err_q      <= err_d;
            data_out_q <= rd_dn_d ? rdata_q : '0;
            if (latch) begin
                idx_q   <= addr_in[DEPTH_LOG2-1:0];
                wdata_q <= data_in;
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) mem[idx_q] <= wdata_q;
        if (ram_re) rdata_q <= mem[idx_q];
    end

    assign read_dn  = rd_dn_q;
    assign write_dn = wr_dn_q;
    assign data_out = data_out_q;
    assign req_err  = err_q;
    assign bus_busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two responders (BASE 0 and BASE 0x400) share one bus;
// read data is checked against a queue of expected words pushed when each read is issued.
module tb_mem_bus_responder;
    logic clk = 1'b0, rst = 1'b0, clk_oe = 1'b1, read_q = 1'b0, write_q = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0] rd_dn, wr_dn, busy, err;
    logic [1:0][31:0] dout;
    int nchk = 0, nerr = 0, to_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model [int];
    int r_lat, r_ndn, r_dirty, r_err;
    logic [31:0] r_dat, exp_d;
    logic r_busy_end, r_busy_after, r_busy_any;

    always #5 clk = ~clk;

    mem_bus_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(10), .BASE(32'h0),
                        .WAIT_RD(1), .WAIT_WR(0)) u0 (
        .clk(clk), .rst(rst), .clk_oe(clk_oe), .read_q(read_q), .write_q(write_q),
        .addr_in(addr), .data_in(wdata), .read_dn(rd_dn[0]), .write_dn(wr_dn[0]),
        .data_out(dout[0]), .bus_busy(busy[0]), .req_err(err[0]));

    mem_bus_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(10), .BASE(32'h400),
                        .WAIT_RD(1), .WAIT_WR(0)) u1 (
        .clk(clk), .rst(rst), .clk_oe(clk_oe), .read_q(read_q), .write_q(write_q),
        .addr_in(addr), .data_in(wdata), .read_dn(rd_dn[1]), .write_dn(wr_dn[1]),
        .data_out(dout[1]), .bus_busy(busy[1]), .req_err(err[1]));

    // Drive one request on unit u, observe up to 40 cycles, hold the request `hold`
    // cycles past the first dn, then drop it. Latency counts edges after the sampling edge.
    task automatic xact(input bit wr, input bit rd, input int u, input logic [31:0] a,
                        input logic [31:0] d, input int oe_off, input int hold);
        logic dn;
        addr = a; wdata = d; write_q = wr; read_q = rd;
        r_lat = -1; r_ndn = 0; r_dirty = 0; r_err = 0; r_dat = '0; r_busy_any = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            clk_oe = !(c >= 2 && c < 2 + oe_off);
            @(posedge clk); #1;
            dn = wr ? wr_dn[u] : rd_dn[u];
            if (err[u]) r_err++;
            if (busy != 2'b00) r_busy_any = 1'b1;
            if (dn) begin
                r_ndn++;
                if (r_lat < 0) begin r_lat = c - 1; r_dat = dout[u]; end
            end else if (dout[u] != '0) r_dirty++;
            if (r_lat >= 0 && c >= r_lat + 1 + hold) break;
        end
        clk_oe = 1'b1;
        r_busy_end = busy[u];
        read_q = 1'b0; write_q = 1'b0; addr = '0; wdata = '0;
        @(posedge clk); #1;
        r_busy_after = busy[u];
        for (int c = 0; c < 10 && busy != 2'b00; c++) begin @(posedge clk); #1; end
        if (busy != 2'b00) to_cnt++;
    endtask

    task automatic test_reset;
        read_q = 1'b1; addr = 32'h5;
        repeat (3) begin @(posedge clk); #1; end
        nchk++; if ({rd_dn, wr_dn, busy, err} !== 8'h0) begin nerr++; $display("FAIL reset_strobes got %b want 0", {rd_dn, wr_dn, busy, err}); end
        nchk++; if (dout !== '0) begin nerr++; $display("FAIL reset_data got %h want 0", dout); end
        read_q = 1'b0; addr = '0; rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        nchk++; if ({rd_dn, wr_dn, busy, err} !== 8'h0) begin nerr++; $display("FAIL post_reset_strobes got %b want 0", {rd_dn, wr_dn, busy, err}); end
        nchk++; if (dout !== '0) begin nerr++; $display("FAIL post_reset_data got %h want 0", dout); end
    endtask

    task automatic test_write_read;
        xact(1, 0, 0, 32'h5, 32'hDEADBEEF, 0, 0);
        nchk++; if (r_lat !== 2) begin nerr++; $display("FAIL wr_latency got %0d want 2", r_lat); end
        exp_q.push_back(32'hDEADBEEF);
        xact(0, 1, 0, 32'h5, '0, 0, 1);
        nchk++; if (r_lat !== 3) begin nerr++; $display("FAIL rd_latency got %0d want 3", r_lat); end
        exp_d = exp_q.pop_front();
        nchk++; if (r_dat !== exp_d) begin nerr++; $display("FAIL rd_data got %h want %h", r_dat, exp_d); end
        nchk++; if (r_dirty !== 0) begin nerr++; $display("FAIL rd_data_outside_dn got %0d want 0", r_dirty); end
        nchk++; if (r_ndn !== 1) begin nerr++; $display("FAIL rd_dn_count got %0d want 1", r_ndn); end
    endtask

    task automatic test_held;
        exp_q.push_back(32'hDEADBEEF);
        xact(0, 1, 0, 32'h5, '0, 0, 10);
        nchk++; if (r_ndn !== 1) begin nerr++; $display("FAIL held_dn_count got %0d want 1", r_ndn); end
        exp_d = exp_q.pop_front();
        nchk++; if (r_dat !== exp_d) begin nerr++; $display("FAIL held_data got %h want %h", r_dat, exp_d); end
        nchk++; if (r_busy_end !== 1'b1) begin nerr++; $display("FAIL held_busy got %b want 1", r_busy_end); end
        nchk++; if (r_busy_after !== 1'b0) begin nerr++; $display("FAIL held_release got %b want 0", r_busy_after); end
    endtask

    task automatic test_miss_wrap;
        xact(0, 1, 1, 32'h800, '0, 0, 0);
        nchk++; if (r_lat !== -1) begin nerr++; $display("FAIL miss_dn got lat %0d want none", r_lat); end
        nchk++; if (r_busy_any !== 1'b0) begin nerr++; $display("FAIL miss_busy got %b want 0", r_busy_any); end
        xact(1, 0, 1, 32'h7FF, 32'hCAFE0001, 0, 0);
        nchk++; if (r_lat !== 2) begin nerr++; $display("FAIL wrap_wr_latency got %0d want 2", r_lat); end
        exp_q.push_back(32'hCAFE0001);
        xact(0, 1, 1, 32'h7FF, '0, 0, 0);
        exp_d = exp_q.pop_front();
        nchk++; if (r_dat !== exp_d) begin nerr++; $display("FAIL wrap_rd_data got %h want %h", r_dat, exp_d); end
    endtask

    task automatic test_conflict;
        xact(1, 1, 1, 32'h400, 32'h12, 0, 0);
        nchk++; if (r_err !== 1) begin nerr++; $display("FAIL conflict_err_pulses got %0d want 1", r_err); end
        nchk++; if (r_lat !== 2) begin nerr++; $display("FAIL conflict_wr_latency got %0d want 2", r_lat); end
        exp_q.push_back(32'h12);
        xact(0, 1, 1, 32'h400, '0, 0, 0);
        exp_d = exp_q.pop_front();
        nchk++; if (r_dat !== exp_d) begin nerr++; $display("FAIL conflict_rd_data got %h want %h", r_dat, exp_d); end
    endtask

    task automatic test_abort_oe;
        int ndn;
        read_q = 1'b1; addr = 32'h5;
        @(posedge clk); #1;
        nchk++; if (busy[0] !== 1'b1) begin nerr++; $display("FAIL abort_accept_busy got %b want 1", busy[0]); end
        read_q = 1'b0; addr = '0; ndn = 0;
        @(posedge clk); #1;
        nchk++; if (busy[0] !== 1'b0) begin nerr++; $display("FAIL abort_idle_busy got %b want 0", busy[0]); end
        repeat (5) begin @(posedge clk); #1; if (rd_dn[0]) ndn++; end
        nchk++; if (ndn !== 0) begin nerr++; $display("FAIL abort_dn got %0d want 0", ndn); end
        exp_q.push_back(32'hDEADBEEF);
        xact(0, 1, 0, 32'h5, '0, 2, 0);
        nchk++; if (r_lat !== 5) begin nerr++; $display("FAIL oe_latency got %0d want 5", r_lat); end
        exp_d = exp_q.pop_front();
        nchk++; if (r_dat !== exp_d) begin nerr++; $display("FAIL oe_data got %h want %h", r_dat, exp_d); end
    endtask

    task automatic test_back_to_back;
        for (int j = 0; j < 6; j++) begin
            model[100 + j * 7] = $urandom;
            xact(1, 0, 0, 32'(100 + j * 7), model[100 + j * 7], 0, 0);
        end
        for (int j = 5; j >= 0; j--) begin
            exp_q.push_back(model[100 + j * 7]);
            xact(0, 1, 0, 32'(100 + j * 7), '0, 0, 0);
            exp_d = exp_q.pop_front();
            nchk++; if (r_dat !== exp_d || r_lat !== 3) begin nerr++; $display("FAIL b2b_rd[%0d] got %h lat %0d want %h lat 3", j, r_dat, r_lat, exp_d); end
        end
    endtask

    task automatic test_timeouts;
        nchk++; if (to_cnt !== 0) begin nerr++; $display("FAIL release_timeouts got %0d want 0", to_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_held();
        test_miss_wrap();
        test_conflict();
        test_abort_oe();
        test_back_to_back();
        test_timeouts();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
